// File: rtl/pulse_seq_if.sv
// Control and converter-side signal bundle for the pulse sequencer.
// The master drives trigger/counts and observes the sequencer outputs; the slave is the sequencer.
interface pulse_seq_if #(
  parameter int TX_W = 14,
  parameter int RX_W = 16
);
  logic            enable;
  logic            trig;
  logic [TX_W-1:0] txsmps;
  logic [RX_W-1:0] rxsmps;
  logic [7:0]      lead;
  logic [7:0]      lag;
  logic            pa_en;
  logic [TX_W-1:0] tx_addr;
  logic            tx_valid;
  logic            rx_gate;
  logic [RX_W-1:0] rx_idx;
  logic            busy;
  logic            done;
  logic [15:0]     missed;

  modport master (
    output enable, trig, txsmps, rxsmps, lead, lag,
    input  pa_en, tx_addr, tx_valid, rx_gate, rx_idx, busy, done, missed
  );

  modport slave (
    input  enable, trig, txsmps, rxsmps, lead, lag,
    output pa_en, tx_addr, tx_valid, rx_gate, rx_idx, busy, done, missed
  );
endinterface

// File: rtl/pulse_seq.sv
// Per-trigger TX/RX sequencer: PA lead-in, DAC address sweep, PA lag-out, and an
// independent ADC receive window that may outlast the PA phase (DRAIN).
module pulse_seq #(
  parameter int TX_W = 14,
  parameter int RX_W = 16
) (
  input logic         clk,
  input logic         rstn,
  pulse_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_TX    = 3'd2,
    ST_LAG   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [TX_W-1:0] TX_ONE = TX_W'(1);
  localparam logic [RX_W-1:0] RX_ONE = RX_W'(1);

  state_t          state_r, state_s;
  logic [7:0]      ph_cnt_r, ph_cnt_s;
  logic [TX_W-1:0] tx_len_r, tx_len_s;
  logic [RX_W-1:0] rx_len_r, rx_len_s;
  logic [7:0]      lead_r, lead_s;
  logic [7:0]      lag_r, lag_s;
  logic            pa_en_r, pa_en_s;
  logic            tx_valid_r, tx_valid_s;
  logic [TX_W-1:0] tx_addr_r, tx_addr_s;
  logic            rx_gate_r, rx_gate_s;
  logic [RX_W-1:0] rx_idx_r, rx_idx_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic [15:0]     missed_r, missed_s;
  logic [TX_W-1:0] tx_last_s;
  logic [RX_W-1:0] rx_last_s;
  logic            abort_s;

  // Counters compare against latched length minus one; only used when the length is non-zero.
  assign tx_last_s = tx_len_r - TX_ONE;
  assign rx_last_s = rx_len_r - RX_ONE;
  assign abort_s   = (state_r != ST_IDLE) && !bus.enable;

  // Next-state and next-output logic for the sequencer and the rx window.
  always_comb begin
    state_s    = state_r;
    ph_cnt_s   = ph_cnt_r;
    tx_len_s   = tx_len_r;
    rx_len_s   = rx_len_r;
    lead_s     = lead_r;
    lag_s      = lag_r;
    pa_en_s    = pa_en_r;
    tx_valid_s = tx_valid_r;
    tx_addr_s  = tx_addr_r;
    rx_gate_s  = rx_gate_r;
    rx_idx_s   = rx_idx_r;
    done_s     = 1'b0;

    if (abort_s) begin
      state_s    = ST_IDLE;
      ph_cnt_s   = 8'd0;
      pa_en_s    = 1'b0;
      tx_valid_s = 1'b0;
      tx_addr_s  = '0;
      rx_gate_s  = 1'b0;
      rx_idx_s   = '0;
    end else begin
      // The rx window runs on its own once opened, regardless of the PA/tx phase.
      if (rx_gate_r) begin
        if (rx_idx_r == rx_last_s) begin
          rx_gate_s = 1'b0;
          rx_idx_s  = '0;
        end else begin
          rx_idx_s = rx_idx_r + RX_ONE;
        end
      end else begin
        rx_idx_s = '0;
      end

      case (state_r)
        ST_IDLE: begin
          if (bus.enable && bus.trig) begin
            state_s  = ST_LEAD;
            ph_cnt_s = 8'd0;
            tx_len_s = bus.txsmps;
            rx_len_s = bus.rxsmps;
            lead_s   = bus.lead;
            lag_s    = bus.lag;
            pa_en_s  = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LEAD: begin
          if (ph_cnt_r == lead_r) begin
            ph_cnt_s = 8'd0;
            if (tx_len_r != '0) begin
              state_s    = ST_TX;
              tx_valid_s = 1'b1;
              tx_addr_s  = '0;
            end else begin
              state_s = ST_LAG;
            end
            if (rx_len_r != '0) begin
              rx_gate_s = 1'b1;
              rx_idx_s  = '0;
            end else begin
              rx_gate_s = 1'b0;
            end
          end else begin
            ph_cnt_s = ph_cnt_r + 8'd1;
          end
        end
        ST_TX: begin
          if (tx_addr_r == tx_last_s) begin
            state_s    = ST_LAG;
            tx_valid_s = 1'b0;
            tx_addr_s  = '0;
            ph_cnt_s   = 8'd0;
          end else begin
            tx_addr_s = tx_addr_r + TX_ONE;
          end
        end
        ST_LAG: begin
          if (ph_cnt_r == lag_r) begin
            pa_en_s  = 1'b0;
            ph_cnt_s = 8'd0;
            if (rx_gate_s) begin
              state_s = ST_DRAIN;
            end else begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end
          end else begin
            ph_cnt_s = ph_cnt_r + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (!rx_gate_s) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          ph_cnt_s   = 8'd0;
          pa_en_s    = 1'b0;
          tx_valid_s = 1'b0;
          tx_addr_s  = '0;
          rx_gate_s  = 1'b0;
          rx_idx_s   = '0;
        end
      endcase
    end

    busy_s = (state_s != ST_IDLE);

    if (bus.trig && (state_r != ST_IDLE) && (missed_r != 16'hFFFF)) begin
      missed_s = missed_r + 16'd1;
    end else begin
      missed_s = missed_r;
    end
  end

  // State, latched pulse parameters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      ph_cnt_r   <= 8'd0;
      tx_len_r   <= '0;
      rx_len_r   <= '0;
      lead_r     <= 8'd0;
      lag_r      <= 8'd0;
      pa_en_r    <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_addr_r  <= '0;
      rx_gate_r  <= 1'b0;
      rx_idx_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      missed_r   <= 16'd0;
    end else begin
      state_r    <= state_s;
      ph_cnt_r   <= ph_cnt_s;
      tx_len_r   <= tx_len_s;
      rx_len_r   <= rx_len_s;
      lead_r     <= lead_s;
      lag_r      <= lag_s;
      pa_en_r    <= pa_en_s;
      tx_valid_r <= tx_valid_s;
      tx_addr_r  <= tx_addr_s;
      rx_gate_r  <= rx_gate_s;
      rx_idx_r   <= rx_idx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      missed_r   <= missed_s;
    end
  end

  assign bus.pa_en    = pa_en_r;
  assign bus.tx_addr  = tx_addr_r;
  assign bus.tx_valid = tx_valid_r;
  assign bus.rx_gate  = rx_gate_r;
  assign bus.rx_idx   = rx_idx_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.missed   = missed_r;

endmodule

// File: tb/tb_pulse_seq.sv
// Directed bench for pulse_seq: per-cycle expected outputs derived from the pulse
// timeline are queued when a trigger is driven and compared as the DUT steps.
module tb_pulse_seq;
  localparam int TX_W = 14;
  localparam int RX_W = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pulse_seq_if #(.TX_W(TX_W), .RX_W(RX_W)) bus ();
  pulse_seq #(.TX_W(TX_W), .RX_W(RX_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic            pa_en;
    logic            tx_valid;
    logic [TX_W-1:0] tx_addr;
    logic            rx_gate;
    logic [RX_W-1:0] rx_idx;
    logic            busy;
    logic            done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   missed_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Cycle on which state is IDLE again, counted from the acceptance cycle.
  function automatic int pulse_len(input int l, input int tx, input int rx, input int lg);
    int d;
    d = l + tx + lg + 3;
    if (rx != 0 && (l + 2 + rx) > d) d = l + 2 + rx;
    return d;
  endfunction

  task automatic push_idle(input int n);
    exp_t e;
    e = '{1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0};
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic push_pulse(input int l, input int tx, input int rx, input int lg);
    exp_t e;
    int   d;
    d = pulse_len(l, tx, rx, lg);
    for (int k = 1; k <= d; k++) begin
      e.pa_en    = (k <= l + tx + lg + 2);
      e.tx_valid = (k >= l + 2) && (k <= l + 1 + tx);
      e.tx_addr  = e.tx_valid ? TX_W'(k - l - 2) : '0;
      e.rx_gate  = (k >= l + 2) && (k <= l + 1 + rx);
      e.rx_idx   = e.rx_gate ? RX_W'(k - l - 2) : '0;
      e.busy     = (k < d);
      e.done     = (k == d);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pa_en", bus.pa_en, e.pa_en);
      chk("tx_valid", bus.tx_valid, e.tx_valid);
      chk("tx_addr", bus.tx_addr, e.tx_addr);
      chk("rx_gate", bus.rx_gate, e.rx_gate);
      chk("rx_idx", bus.rx_idx, e.rx_idx);
      chk("busy", bus.busy, e.busy);
      chk("done", bus.done, e.done);
    end
  endtask

  task automatic start(input int l, input int tx, input int rx, input int lg);
    bus.lead   = 8'(l);
    bus.txsmps = TX_W'(tx);
    bus.rxsmps = RX_W'(rx);
    bus.lag    = 8'(lg);
    bus.trig   = 1'b1;
    push_pulse(l, tx, rx, lg);
    tick();
    bus.trig   = 1'b0;
  endtask

  task automatic run_pulse(input int l, input int tx, input int rx, input int lg);
    start(l, tx, rx, lg);
    repeat (pulse_len(l, tx, rx, lg) - 1) tick();
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.trig   = 1'b0;
    bus.txsmps = '0;
    bus.rxsmps = '0;
    bus.lead   = 8'd0;
    bus.lag    = 8'd0;
    rstn       = 1'b1;
    #2 rstn    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pa_en", bus.pa_en, 1'b0);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_tx_addr", bus.tx_addr, 0);
    chk("rst_rx_gate", bus.rx_gate, 1'b0);
    chk("rst_rx_idx", bus.rx_idx, 0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_missed", bus.missed, 0);
    rstn       = 1'b1;
    bus.enable = 1'b1;
    push_idle(2);
    repeat (2) tick();

    // Basic pulse, then short rx window, then all-zero counts.
    run_pulse(2, 4, 6, 1);
    push_idle(1); tick();
    run_pulse(2, 4, 2, 1);
    push_idle(1); tick();
    run_pulse(0, 0, 0, 0);
    push_idle(1); tick();
    run_pulse(1, 3, 12, 0);
    push_idle(1); tick();

    // Three triggers dropped mid-pulse; timeline must be unchanged.
    start(2, 4, 6, 1);
    tick();
    repeat (3) begin
      bus.trig = 1'b1; tick();
      bus.trig = 1'b0; tick();
      missed_exp++;
    end
    repeat (2) tick();
    push_idle(1); tick();
    chk("missed_mid_pulse", bus.missed, 16'(missed_exp));

    // Trigger while disabled in IDLE is ignored and not counted.
    bus.enable = 1'b0;
    bus.trig   = 1'b1;
    push_idle(1); tick();
    bus.trig   = 1'b0;
    push_idle(1); tick();
    chk("missed_disabled", bus.missed, 16'(missed_exp));
    bus.enable = 1'b1;

    // Abort during TX once tx_addr reaches 2.
    start(2, 4, 6, 1);
    repeat (5) tick();
    exp_q.delete();
    bus.enable = 1'b0;
    push_idle(3);
    repeat (3) tick();
    bus.enable = 1'b1;
    run_pulse(2, 4, 6, 1);
    push_idle(1); tick();

    // Mid-pulse txsmps change is not seen; trig coincident with done starts at once.
    start(2, 4, 6, 1);
    tick();
    bus.txsmps = TX_W'(8);
    repeat (8) tick();
    bus.trig = 1'b1;
    push_pulse(2, 8, 6, 1);
    tick();
    bus.trig = 1'b0;
    repeat (pulse_len(2, 8, 6, 1) - 1) tick();
    push_idle(2);
    repeat (2) tick();
    chk("missed_after_b2b", bus.missed, 16'(missed_exp));
    chk("queue_drained", exp_q.size(), 0);

    // Saturation: hold trig high across long pulses for 70000 cycles.
    bus.lead   = 8'd0;
    bus.lag    = 8'd0;
    bus.txsmps = TX_W'(1);
    bus.rxsmps = RX_W'(65535);
    bus.trig   = 1'b1;
    repeat (70000) tick();
    bus.trig   = 1'b0;
    chk("missed_saturated", bus.missed, 16'hFFFF);
    bus.enable = 1'b0;
    repeat (2) tick();
    chk("busy_after_abort", bus.busy, 1'b0);
    chk("pa_en_after_abort", bus.pa_en, 1'b0);
    chk("missed_held", bus.missed, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
